// File: rtl/req_ack_pkg.sv
// Shared types for the clocked REQ/ACK receiver: FSM encoding and synchronizer depth.
package req_ack_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, ACK} rx_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; power-of-2 depth, pointers wrap naturally.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/req_ack_receiver.sv
// Clocked receiver for the 4-phase REQ/ACK handshake: sync REQ, settle, capture into
// a FIFO, acknowledge, and check the words count up 0, 1, 2, ...
module req_ack_receiver #(
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int SETTLE    = 2,
  parameter bit SEQ_CHECK = 1'b1,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_in,
  input  logic [DW-1:0] data_in,
  output logic          ack_out,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [LW-1:0] fifo_level,
  output logic [31:0]   word_count,
  output logic          seq_err,
  output logic          proto_err
);
  import req_ack_pkg::*;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  rx_state_t              state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   push, proto_set, full, empty;
  logic [DW-1:0]          expected;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    proto_set = 1'b0;
    case (state)
      IDLE:
        // registered level: a same-cycle pop does not unblock a full FIFO
        if (req_s && !full) begin
          state_nxt = req_ack_pkg::SETTLE;
          cnt_nxt   = CW'(SETTLE - 1);
        end
      req_ack_pkg::SETTLE:
        if (!req_s) begin
          proto_set = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = CAPTURE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      CAPTURE: begin
        push      = 1'b1;
        state_nxt = ACK;
      end
      ACK:
        if (!req_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ack_out    <= 1'b0;
      word_count <= '0;
      expected   <= '0;
      seq_err    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // ACK is raised as CAPTURE is entered and held until REQ is seen low
      ack_out <= (state_nxt == CAPTURE) || (state_nxt == ACK);
      if (proto_set) proto_err <= 1'b1;
      if (push) begin
        word_count <= word_count + 1'b1;
        expected   <= data_in + 1'b1;
        if (SEQ_CHECK && (data_in != expected)) seq_err <= 1'b1;
      end
    end
  end

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_in),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level),
    .head      (out_data)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_req_ack_receiver.sv
// Directed bench for req_ack_receiver: timing, sequence check, backpressure, glitch, reset.
module tb_req_ack_receiver;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          out_ready = 1'b0;
  logic          ack_out, out_valid, seq_err, proto_err;
  logic [DW-1:0] out_data;
  logic [LW-1:0] fifo_level;
  logic [31:0]   word_count;

  logic          req4 = 1'b0;
  logic          ready4 = 1'b0;
  logic          ack4, valid4, seq4, proto4;
  logic [DW-1:0] data4;
  logic [LW-1:0] level4;
  logic [31:0]   count4;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] got[$];

  req_ack_receiver #(.DW(DW), .DEPTH(DEPTH), .SETTLE(2), .SEQ_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_level(fifo_level), .word_count(word_count), .seq_err(seq_err), .proto_err(proto_err)
  );

  req_ack_receiver #(.DW(DW), .DEPTH(DEPTH), .SETTLE(4), .SEQ_CHECK(1'b1)) dut4 (
    .clk(clk), .rst(rst), .req_in(req4), .data_in(32'h0), .ack_out(ack4),
    .out_valid(valid4), .out_data(data4), .out_ready(ready4),
    .fifo_level(level4), .word_count(count4), .seq_err(seq4), .proto_err(proto4)
  );

  always @(negedge clk) if (out_valid && out_ready) got.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (ack_out !== v && n < 50) begin
      cyc(1);
      n++;
    end
    chk(tag, ack_out, v);
  endtask

  task automatic send(input logic [31:0] d);
    data_in = d;
    req_in  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    cyc(2);
    req_in = 1'b0;
    wait_ack(1'b0, "ack_fall");
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_in = 1'b0;
    req4 = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    int n;
    logic saw;
    cyc(1);
    do_reset();
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", word_count, 0);
    chk("rst_seq", seq_err, 0);
    chk("rst_proto", proto_err, 0);

    // basic handshake latency
    data_in = 0;
    req_in = 1'b1;
    n = 0;
    while (!ack_out && n < 20) begin cyc(1); n++; end
    chk("rise_lat", n, 5);
    cyc(2);
    req_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin cyc(1); n++; end
    chk("fall_lat", n, 3);
    chk("basic_data", out_data, 0);
    chk("basic_valid", out_valid, 1);
    chk("basic_count", word_count, 1);
    chk("basic_seq", seq_err, 0);
    chk("basic_proto", proto_err, 0);

    // sequence break and resync
    cyc(1);
    do_reset();
    out_ready = 1'b1;
    send(0);
    send(1);
    chk("seq_ok", seq_err, 0);
    send(3);
    chk("seq_set", seq_err, 1);
    send(4);
    chk("seq_sticky", seq_err, 1);
    chk("seq_count", word_count, 4);
    out_ready = 1'b0;
    cyc(2);
    send(5);
    send(6);
    chk("pre_rst_level", fifo_level, 2);
    chk("pre_rst_seq", seq_err, 1);

    // reset while ACK is high
    data_in = 7;
    req_in = 1'b1;
    wait_ack(1'b1, "midack_high");
    rst = 1'b1;
    req_in = 1'b0;
    cyc(1);
    chk("midrst_ack", ack_out, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_count", word_count, 0);
    chk("midrst_seq", seq_err, 0);
    chk("midrst_proto", proto_err, 0);
    rst = 1'b0;
    cyc(1);
    send(0);
    chk("postrst_seq", seq_err, 0);
    chk("postrst_count", word_count, 1);
    chk("postrst_data", out_data, 0);

    // backpressure on a full FIFO
    do_reset();
    got.delete();
    for (int i = 0; i < 4; i++) send(i);
    chk("bp_level_full", fifo_level, 4);
    data_in = 4;
    req_in = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (ack_out) saw = 1'b1; end
    chk("bp_no_ack", saw, 0);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    wait_ack(1'b1, "bp_ack_after_pop");
    cyc(2);
    req_in = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    cyc(1);
    chk("bp_level_after", fifo_level, 4);
    out_ready = 1'b1;
    cyc(8);
    out_ready = 1'b0;
    chk("bp_nwords", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_order", got[i], i);

    // REQ glitch shorter than settle on the SETTLE=4 instance
    do_reset();
    req4 = 1'b1;
    cyc(3);
    req4 = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (ack4) saw = 1'b1; end
    chk("glitch_proto", proto4, 1);
    chk("glitch_no_ack", saw, 0);
    chk("glitch_count", count4, 0);
    chk("glitch_level", level4, 0);

    // 100-word stream
    do_reset();
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) send(i);
    cyc(4);
    chk("stream_nwords", got.size(), 100);
    for (int i = 0; i < 100 && i < got.size(); i++) chk("stream_word", got[i], i);
    chk("stream_count", word_count, 100);
    chk("stream_seq", seq_err, 0);
    chk("stream_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
